// File: rtl/irq_prio_pkg.sv
// Shared types and width helpers for the interrupt priority controller.
package irq_prio_pkg;

    // Two-state presentation FSM: IDLE searches, PRESENT holds a winner until acked.
    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } irq_state_t;

    // Index width for n items, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width able to hold a count from 0 to n inclusive.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/irq_prio_pick.sv
// Find-first-set over W bits, starting at start_i and wrapping modulo W.
// With start_i tied to zero this is a plain lowest-index priority encoder.
module irq_prio_pick #(
    parameter int W  = 9,
    parameter int IW = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]  vec_i,
    input  logic [IW-1:0] start_i,
    output logic          found_o,
    output logic [IW-1:0] idx_o
);

    int pos;

    // Scan from the farthest position back towards start_i so the closest set bit is written last.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        pos     = 0;
        for (int i = W - 1; i >= 0; i--) begin
            pos = (int'(start_i) + i) % W;
            if (vec_i[pos]) begin
                found_o = 1'b1;
                idx_o   = IW'(pos);
            end
        end
    end

endmodule

// File: rtl/irq_prio_ctrl.sv
// Interrupt priority controller: NUM_GRP groups x NUM_CH channels.
// Request edges set pending bits; the lowest group with an enabled pending
// channel wins and is held on a valid/ready port until acknowledged.
// Optional feature: define IRQ_PRIO_RR_EN for per-group round-robin channel order.
module irq_prio_ctrl
    import irq_prio_pkg::*;
#(
    parameter int NUM_CH  = 9,
    parameter int NUM_GRP = 3
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_GRP*NUM_CH-1:0]          irq_req,
    input  logic [NUM_CH-1:0]                  ch_en,
    output logic                               irq_valid,
    output logic [idx_w(NUM_GRP)-1:0]          irq_grp,
    output logic [idx_w(NUM_CH)-1:0]           irq_ch,
    input  logic                               irq_ready,
    output logic                               irq_any,
    output logic [cnt_w(NUM_GRP*NUM_CH)-1:0]   irq_pending_cnt
);

    localparam int N  = NUM_GRP * NUM_CH;
    localparam int GW = idx_w(NUM_GRP);
    localparam int CW = idx_w(NUM_CH);
    localparam int NW = cnt_w(N);

    // Handshake: the winner is offered while irq_valid=1 and consumed on a cycle
    // where irq_valid & irq_ready are both high; irq_ready alone has no effect.

    irq_state_t    state_q, state_d;
    logic [GW-1:0] grp_q, grp_d;
    logic [CW-1:0] ch_q, ch_d;
    logic [N-1:0]  req_q, pending_q, pending_d, clr_vec;
    logic          any_q;
    logic [NW-1:0] cnt_q, cnt_d;
    logic          ack;

    logic [NUM_GRP-1:0] grp_found;
    logic [CW-1:0]      grp_idx [NUM_GRP];
    logic               win_found;
    logic [GW-1:0]      win_grp;
    logic [CW-1:0]      win_ch;

`ifdef IRQ_PRIO_RR_EN
    logic [CW-1:0] ptr_q [NUM_GRP];
`endif

    assign ack             = (state_q == PRESENT) && irq_ready;
    assign irq_valid       = (state_q == PRESENT);
    assign irq_grp         = grp_q;
    assign irq_ch          = ch_q;
    assign irq_any         = any_q;
    assign irq_pending_cnt = cnt_q;

    // One channel search per group over its enabled pending bits.
    for (genvar g = 0; g < NUM_GRP; g++) begin : g_pick
        logic [CW-1:0] start;
`ifdef IRQ_PRIO_RR_EN
        assign start = (ptr_q[g] == CW'(NUM_CH - 1)) ? '0 : ptr_q[g] + CW'(1);
`else
        assign start = '0;
`endif
        irq_prio_pick #(
            .W  (NUM_CH),
            .IW (CW)
        ) u_pick (
            .vec_i   (pending_q[g*NUM_CH +: NUM_CH] & ch_en),
            .start_i (start),
            .found_o (grp_found[g]),
            .idx_o   (grp_idx[g])
        );
    end

    // Lowest-numbered group with a candidate wins; scanned downwards so group 0 is written last.
    always_comb begin
        win_found = 1'b0;
        win_grp   = '0;
        win_ch    = '0;
        for (int g = NUM_GRP - 1; g >= 0; g--) begin
            if (grp_found[g]) begin
                win_found = 1'b1;
                win_grp   = GW'(g);
                win_ch    = grp_idx[g];
            end
        end
    end

    // Next pending vector: the acked bit clears, a fresh edge sets and overrides the clear.
    always_comb begin
        clr_vec = '0;
        for (int i = 0; i < N; i++) begin
            if (ack && (i == int'(grp_q) * NUM_CH + int'(ch_q))) begin
                clr_vec[i] = 1'b1;
            end
        end
        pending_d = (pending_q & ~clr_vec) | (irq_req & ~req_q);
        cnt_d = '0;
        for (int i = 0; i < N; i++) begin
            cnt_d = cnt_d + NW'(pending_d[i]);
        end
    end

    // FSM next state: capture a winner from IDLE, hold it in PRESENT until acked.
    always_comb begin
        state_d = state_q;
        grp_d   = grp_q;
        ch_d    = ch_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d = PRESENT;
                    grp_d   = win_grp;
                    ch_d    = win_ch;
                end
            end
            PRESENT: begin
                if (irq_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state and presented winner registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grp_q   <= '0;
            ch_q    <= '0;
        end else begin
            state_q <= state_d;
            grp_q   <= grp_d;
            ch_q    <= ch_d;
        end
    end

    // Request history, pending bits and the status outputs derived from next-state pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q     <= '0;
            pending_q <= '0;
            any_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            req_q     <= irq_req;
            pending_q <= pending_d;
            any_q     <= |pending_d;
            cnt_q     <= cnt_d;
        end
    end

`ifdef IRQ_PRIO_RR_EN
    // Round-robin pointers: the acked group remembers its granted channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int g = 0; g < NUM_GRP; g++) begin
                ptr_q[g] <= '0;
            end
        end else if (ack) begin
            ptr_q[grp_q] <= ch_q;
        end
    end
`endif

endmodule

// File: tb/tb_irq_prio_ctrl.sv
// Bench for irq_prio_ctrl: directed scenarios plus randomized traffic against a
// cycle-level behavioural model of pending bits, arbitration and handshake.
module tb_irq_prio_ctrl;

    localparam int NC = 9;
    localparam int NG = 3;
    localparam int N  = NC * NG;
    localparam int GW = (NG > 1) ? $clog2(NG) : 1;
    localparam int CW = (NC > 1) ? $clog2(NC) : 1;
    localparam int NW = $clog2(N + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  irq_req;
    logic [NC-1:0] ch_en;
    logic          irq_valid;
    logic [GW-1:0] irq_grp;
    logic [CW-1:0] irq_ch;
    logic          irq_ready;
    logic          irq_any;
    logic [NW-1:0] irq_pending_cnt;

    int checks = 0;
    int errors = 0;

    // Clock
    always #5 clk = ~clk;

    irq_prio_ctrl #(
        .NUM_CH  (NC),
        .NUM_GRP (NG)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .irq_req         (irq_req),
        .ch_en           (ch_en),
        .irq_valid       (irq_valid),
        .irq_grp         (irq_grp),
        .irq_ch          (irq_ch),
        .irq_ready       (irq_ready),
        .irq_any         (irq_any),
        .irq_pending_cnt (irq_pending_cnt)
    );

    // Behavioural model state
    bit m_pend [N];
    bit m_prev [N];
    bit m_present;
    int m_grp;
    int m_ch;
    int m_ptr [NG];

    function automatic int m_count();
        int c = 0;
        foreach (m_pend[i]) c += int'(m_pend[i]);
        return c;
    endfunction

    task automatic model_reset();
        foreach (m_pend[i]) begin
            m_pend[i] = 1'b0;
            m_prev[i] = 1'b0;
        end
        foreach (m_ptr[g]) m_ptr[g] = 0;
        m_present = 1'b0;
        m_grp = 0;
        m_ch  = 0;
    endtask

    // Advance model by one clock using current inputs, then step the DUT and settle.
    task automatic tick();
        bit nxt [N];
        bit ack;
        bit found;
        int start;
        int c;
        ack = m_present && irq_ready;
        nxt = m_pend;
        if (ack) nxt[m_grp * NC + m_ch] = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (irq_req[i] && !m_prev[i]) nxt[i] = 1'b1;
        end
        if (!m_present) begin
            found = 1'b0;
            for (int g = 0; g < NG && !found; g++) begin
`ifdef IRQ_PRIO_RR_EN
                start = (m_ptr[g] + 1) % NC;
`else
                start = 0;
`endif
                for (int k = 0; k < NC && !found; k++) begin
                    c = (start + k) % NC;
                    if (m_pend[g * NC + c] && ch_en[c]) begin
                        found = 1'b1;
                        m_grp = g;
                        m_ch  = c;
                    end
                end
            end
            m_present = found;
        end else if (ack) begin
            m_present = 1'b0;
`ifdef IRQ_PRIO_RR_EN
            m_ptr[m_grp] = m_ch;
`endif
        end
        m_pend = nxt;
        for (int i = 0; i < N; i++) m_prev[i] = irq_req[i];
        @(posedge clk);
        #1;
    endtask

    // Reset block
    task automatic apply_reset();
        irq_req   = '0;
        irq_ready = 1'b0;
        ch_en     = '1;
        rst_n     = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (irq_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0d exp 0", irq_valid); end
        checks++; if (irq_grp !== '0) begin errors++; $display("FAIL reset_grp got %0d exp 0", irq_grp); end
        checks++; if (irq_ch !== '0) begin errors++; $display("FAIL reset_ch got %0d exp 0", irq_ch); end
        checks++; if (irq_any !== 1'b0) begin errors++; $display("FAIL reset_any got %0d exp 0", irq_any); end
        checks++; if (irq_pending_cnt !== '0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", irq_pending_cnt); end
    endtask

    task automatic test_single();
        apply_reset();
        irq_ready   = 1'b1;
        irq_req[13] = 1'b1;
        tick();
        irq_req = '0;
        checks++; if (irq_pending_cnt !== NW'(1)) begin errors++; $display("FAIL single_cnt_set got %0d exp 1", irq_pending_cnt); end
        checks++; if (irq_any !== 1'b1) begin errors++; $display("FAIL single_any got %0d exp 1", irq_any); end
        checks++; if (irq_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid got %0d exp 0", irq_valid); end
        tick();
        checks++; if (irq_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %0d exp 1", irq_valid); end
        checks++; if (irq_grp !== GW'(1)) begin errors++; $display("FAIL single_grp got %0d exp 1", irq_grp); end
        checks++; if (irq_ch !== CW'(4)) begin errors++; $display("FAIL single_ch got %0d exp 4", irq_ch); end
        tick();
        checks++; if (irq_valid !== 1'b0) begin errors++; $display("FAIL single_after_ack_valid got %0d exp 0", irq_valid); end
        checks++; if (irq_pending_cnt !== NW'(0)) begin errors++; $display("FAIL single_cnt_clear got %0d exp 0", irq_pending_cnt); end
    endtask

    task automatic test_priority();
        apply_reset();
        irq_ready   = 1'b0;
        irq_req[20] = 1'b1;
        irq_req[3]  = 1'b1;
        tick();
        irq_req = '0;
        tick();
        checks++; if (irq_pending_cnt !== NW'(2)) begin errors++; $display("FAIL prio_cnt got %0d exp 2", irq_pending_cnt); end
        for (int i = 0; i < 10; i++) begin
            if (i == 4) ch_en[3] = 1'b0;
            if (i == 7) ch_en = '1;
            checks++;
            if (irq_valid !== 1'b1 || irq_grp !== GW'(0) || irq_ch !== CW'(3)) begin
                errors++;
                $display("FAIL prio_hold cycle %0d got v%0d g%0d c%0d exp v1 g0 c3", i, irq_valid, irq_grp, irq_ch);
            end
            tick();
        end
        irq_ready = 1'b1;
        tick();
        checks++; if (irq_valid !== 1'b0) begin errors++; $display("FAIL prio_idle_gap got %0d exp 0", irq_valid); end
        tick();
        checks++;
        if (irq_valid !== 1'b1 || irq_grp !== GW'(2) || irq_ch !== CW'(2)) begin
            errors++;
            $display("FAIL prio_second got v%0d g%0d c%0d exp v1 g2 c2", irq_valid, irq_grp, irq_ch);
        end
        tick();
        checks++; if (irq_pending_cnt !== NW'(0)) begin errors++; $display("FAIL prio_cnt_end got %0d exp 0", irq_pending_cnt); end
    endtask

    task automatic test_mask();
        apply_reset();
        irq_ready  = 1'b1;
        ch_en[5]   = 1'b0;
        irq_req[5] = 1'b1;
        tick();
        irq_req = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (irq_valid !== 1'b0 || irq_any !== 1'b1 || irq_pending_cnt !== NW'(1)) begin
                errors++;
                $display("FAIL mask_hold got v%0d any%0d cnt%0d exp v0 any1 cnt1", irq_valid, irq_any, irq_pending_cnt);
            end
        end
        ch_en = '1;
        tick();
        checks++;
        if (irq_valid !== 1'b1 || irq_grp !== GW'(0) || irq_ch !== CW'(5)) begin
            errors++;
            $display("FAIL mask_release got v%0d g%0d c%0d exp v1 g0 c5", irq_valid, irq_grp, irq_ch);
        end
        tick();
        checks++; if (irq_pending_cnt !== NW'(0)) begin errors++; $display("FAIL mask_cnt_end got %0d exp 0", irq_pending_cnt); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        irq_ready  = 1'b0;
        irq_req[0] = 1'b1;
        tick();
        irq_req = '0;
        tick();
        checks++; if (irq_valid !== 1'b1 || irq_ch !== CW'(0)) begin errors++; $display("FAIL reack_first got v%0d c%0d exp v1 c0", irq_valid, irq_ch); end
        irq_ready  = 1'b1;
        irq_req[0] = 1'b1;
        tick();
        irq_req = '0;
        checks++; if (irq_valid !== 1'b0) begin errors++; $display("FAIL reack_gap got %0d exp 0", irq_valid); end
        checks++; if (irq_pending_cnt !== NW'(1)) begin errors++; $display("FAIL reack_cnt got %0d exp 1", irq_pending_cnt); end
        tick();
        checks++;
        if (irq_valid !== 1'b1 || irq_grp !== GW'(0) || irq_ch !== CW'(0)) begin
            errors++;
            $display("FAIL reack_regrant got v%0d g%0d c%0d exp v1 g0 c0", irq_valid, irq_grp, irq_ch);
        end
        tick();
        checks++; if (irq_pending_cnt !== NW'(0)) begin errors++; $display("FAIL reack_cnt_end got %0d exp 0", irq_pending_cnt); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        irq_ready   = 1'b0;
        irq_req[7]  = 1'b1;
        irq_req[15] = 1'b1;
        tick();
        irq_req = '0;
        tick();
        checks++; if (irq_valid !== 1'b1) begin errors++; $display("FAIL areset_pre_valid got %0d exp 1", irq_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (irq_valid !== 1'b0 || irq_any !== 1'b0 || irq_pending_cnt !== NW'(0)) begin
            errors++;
            $display("FAIL areset_async got v%0d any%0d cnt%0d exp 0 0 0", irq_valid, irq_any, irq_pending_cnt);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        irq_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (irq_valid !== 1'b0 || irq_pending_cnt !== NW'(0)) begin
                errors++;
                $display("FAIL areset_lost got v%0d cnt%0d exp v0 cnt0", irq_valid, irq_pending_cnt);
            end
        end
    endtask

    task automatic test_rr_order();
        logic [CW-1:0] exp_q [$];
        logic [CW-1:0] exp_ch;
        bit            seen;
        apply_reset();
`ifdef IRQ_PRIO_RR_EN
        exp_q = '{CW'(0), CW'(1), CW'(2), CW'(0)};
`else
        exp_q = '{CW'(0), CW'(0), CW'(0), CW'(0)};
`endif
        irq_ready  = 1'b1;
        irq_req[0] = 1'b1;
        tick();
        irq_req = '0;
        for (int n = 0; n < 4; n++) begin
            seen = 1'b0;
            for (int t = 0; t < 4 && !seen; t++) begin
                if (irq_valid === 1'b1) seen = 1'b1;
                else tick();
            end
            exp_ch = exp_q.pop_front();
            checks++;
            if (!seen) begin
                errors++;
                $display("FAIL rr_timeout grant %0d got no valid exp c%0d", n, exp_ch);
            end else if (irq_ch !== exp_ch || irq_grp !== GW'(0)) begin
                errors++;
                $display("FAIL rr_order grant %0d got g%0d c%0d exp g0 c%0d", n, irq_grp, irq_ch, exp_ch);
            end
            if (seen) begin
                irq_req[irq_ch] = 1'b1;
                if (n == 0) begin
                    irq_req[1] = 1'b1;
                    irq_req[2] = 1'b1;
                end
                tick();
                irq_req = '0;
            end
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            irq_req = N'($urandom & $urandom & $urandom);
            if (cyc % 16 == 0) ch_en = ($urandom_range(0, 3) == 0) ? NC'($urandom) : '1;
            irq_ready = ($urandom_range(0, 2) != 0);
            tick();
            checks++;
            if (irq_valid !== m_present) begin
                errors++;
                $display("FAIL rand_valid cycle %0d got %0d exp %0d", cyc, irq_valid, m_present);
            end
            checks++;
            if (irq_any !== (m_count() != 0) || irq_pending_cnt !== NW'(m_count())) begin
                errors++;
                $display("FAIL rand_status cycle %0d got any%0d cnt%0d exp cnt%0d", cyc, irq_any, irq_pending_cnt, m_count());
            end
            if (m_present) begin
                checks++;
                if (irq_grp !== GW'(m_grp) || irq_ch !== CW'(m_ch)) begin
                    errors++;
                    $display("FAIL rand_winner cycle %0d got g%0d c%0d exp g%0d c%0d", cyc, irq_grp, irq_ch, m_grp, m_ch);
                end
            end
        end
    endtask

    // Safety net against a stuck run
    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_mask();
        test_back_to_back();
        test_async_reset();
        test_rr_order();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
